// File: rtl/rld_app_traffic_gen.sv
// Application-side traffic generator for the RLDRAM-II controller user FIFOs.
// Each pass writes a deterministic pattern over NUM_CMDS bursts, reads them
// back in order, and compares every returned word. It reports error and pass
// counts, plus a read-data watchdog.
module rld_app_traffic_gen #(
  parameter int RL_DQ_WIDTH  = 72,
  parameter int APP_AD_WIDTH = 26,
  parameter int BASE_ADDR    = 0,
  parameter int ADDR_STRIDE  = 4,
  parameter int NUM_CMDS     = 256,
  parameter int TIMEOUT      = 4096,
  parameter int LOOP         = 1
) (
  input  logic                       sysClk,
  input  logic                       sysRst_n,
  input  logic                       start,
  input  logic                       app_init_done,
  output logic                       app_cmd_valid,
  input  logic                       app_cmd_ready,
  output logic                       app_cmd_wr,
  output logic [APP_AD_WIDTH-1:0]    app_addr,
  output logic                       app_wdata_valid,
  input  logic                       app_wdata_ready,
  output logic [2*RL_DQ_WIDTH-1:0]   app_wdata,
  input  logic                       app_rdata_valid,
  input  logic [2*RL_DQ_WIDTH-1:0]   app_rdata,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       timeout,
  output logic [15:0]                err_count,
  output logic [7:0]                 pass_count
);
  localparam int DW  = 2*RL_DQ_WIDTH;
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [16:0] NWORDS = 17'(2*NUM_CMDS);
  localparam logic [15:0] LAST   = 16'(NUM_CMDS-1);
  localparam logic [APP_AD_WIDTH-1:0] BASE = APP_AD_WIDTH'(BASE_ADDR);
  localparam logic [APP_AD_WIDTH-1:0] STEP = APP_AD_WIDTH'(ADDR_STRIDE);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_INIT, S_WR_D0, S_WR_D1, S_WR_CMD, S_RD_CMD, S_WAIT_RD, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             idx_q, idx_d;
  logic [APP_AD_WIDTH-1:0] addr_q, addr_d;
  logic                    pend_q, pend_d;
  logic [16:0]             rcnt_q, rcnt_d;
  logic [WDW-1:0]          wd_q, wd_d;
  logic                    timeout_q, timeout_d;
  logic                    ign_q, ign_d;
  logic                    mism_q, mism_d;
  logic                    spur_q, spur_d;
  logic [15:0]             err_q, err_d;
  logic [7:0]              pc_q, pc_d;

  logic vld, in_rd, rd_ok, wd_expire;
  logic [DW-1:0] exp_word;

  // 16-bit seed {idx, beat} ^ {pass, 8'h00}, replicated across the user word.
  function automatic logic [DW-1:0] pattern(input logic [14:0] idx, input logic beat,
                                            input logic [7:0] pcnt);
    logic [15:0]   v;
    logic [DW-1:0] w;
    v = {idx, beat} ^ {pcnt, 8'h00};
    for (int k = 0; k < DW; k++) w[k] = v[k % 16];
    return w;
  endfunction

  // A valid once raised stays up until accepted, even if init_done drops.
  assign vld = (state_q inside {S_WR_D0, S_WR_D1, S_WR_CMD, S_RD_CMD}) &&
               (app_init_done || pend_q);
  assign app_cmd_valid   = vld && (state_q inside {S_WR_CMD, S_RD_CMD});
  assign app_wdata_valid = vld && (state_q inside {S_WR_D0, S_WR_D1});
  assign app_cmd_wr      = (state_q == S_WR_CMD);
  assign app_addr        = addr_q;
  assign app_wdata       = pattern(idx_q[14:0], state_q == S_WR_D1, pc_q);
  assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done            = (state_q == S_DONE);
  assign pass            = done && (err_q == 16'h0) && !timeout_q;
  assign timeout         = timeout_q;
  assign err_count       = err_q;
  assign pass_count      = pc_q;

  assign in_rd    = (state_q == S_RD_CMD) || (state_q == S_WAIT_RD);
  assign rd_ok    = app_rdata_valid && in_rd && (rcnt_q < NWORDS);
  assign exp_word = pattern(rcnt_q[15:1], rcnt_q[0], pc_q);

  // Read check stage and watchdog; read issues also restart the idle count.
  always_comb begin
    mism_d    = rd_ok && (app_rdata != exp_word);
    spur_d    = app_rdata_valid && !rd_ok && !ign_q;
    wd_d      = '0;
    wd_expire = 1'b0;
    if (in_rd && !app_rdata_valid && !(app_cmd_valid && app_cmd_ready)) begin
      if (wd_q == WDW'(TIMEOUT-1)) wd_expire = 1'b1;
      else                         wd_d      = wd_q + 1'b1;
    end
  end

  // Sequencer next-state and counter updates.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    pc_d      = pc_q;
    timeout_d = timeout_q;
    ign_d     = ign_q;
    pend_d    = (app_cmd_valid && !app_cmd_ready) || (app_wdata_valid && !app_wdata_ready);
    rcnt_d    = rd_ok ? rcnt_q + 17'd1 : rcnt_q;
    err_d     = ((mism_q || spur_q) && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_WAIT_INIT; err_d = '0; timeout_d = 1'b0;
      end
      S_WAIT_INIT: if (app_init_done) begin
        state_d = S_WR_D0; idx_d = '0; addr_d = BASE;
      end
      S_WR_D0: if (app_wdata_valid && app_wdata_ready) state_d = S_WR_D1;
      S_WR_D1: if (app_wdata_valid && app_wdata_ready) state_d = S_WR_CMD;
      S_WR_CMD: if (app_cmd_valid && app_cmd_ready) begin
        if (idx_q == LAST) begin
          state_d = S_RD_CMD; idx_d = '0; addr_d = BASE; rcnt_d = '0; ign_d = 1'b0;
        end else begin
          state_d = S_WR_D0; idx_d = idx_q + 16'd1; addr_d = addr_q + STEP;
        end
      end
      S_RD_CMD: if (app_cmd_valid && app_cmd_ready) begin
        if (idx_q == LAST) state_d = S_WAIT_RD;
        else begin
          idx_d = idx_q + 16'd1; addr_d = addr_q + STEP;
        end
      end
      S_WAIT_RD: if (rcnt_q == NWORDS) state_d = S_DONE;
      S_DONE: begin
        if ((LOOP != 0) && pass) begin
          state_d = S_WR_D0; idx_d = '0; addr_d = BASE; pc_d = pc_q + 8'd1; err_d = '0;
        end else if (start) begin
          state_d = S_WAIT_INIT; err_d = '0; timeout_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Watchdog abort: late returns are ignored until the next read phase.
    if (wd_expire) begin
      state_d = S_DONE; timeout_d = 1'b1; ign_d = 1'b1; pend_d = 1'b0;
    end
  end

  // State and counter registers.
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      addr_q    <= '0;
      pend_q    <= 1'b0;
      rcnt_q    <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      ign_q     <= 1'b1;
      mism_q    <= 1'b0;
      spur_q    <= 1'b0;
      err_q     <= '0;
      pc_q      <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      pend_q    <= pend_d;
      rcnt_q    <= rcnt_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      ign_q     <= ign_d;
      mism_q    <= mism_d;
      spur_q    <= spur_d;
      err_q     <= err_d;
      pc_q      <= pc_d;
    end
  end
endmodule

// File: tb/tb_rld_app_traffic_gen.sv
// Directed bench for rld_app_traffic_gen. Two instances share one loopback
// memory model: inst 0 has LOOP=0 and inst 1 has LOOP=1. Both use NUM_CMDS=4
// and TIMEOUT=16. The sel variable picks which instance the model serves.
module tb_rld_app_traffic_gen;
  localparam int DW = 144;
  localparam int AW = 26;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, init_done;
  logic start[2];
  logic cv[2], cwr[2], wv[2], busy[2], done[2], pass[2], tmo[2];
  logic [AW-1:0] ad[2];
  logic [DW-1:0] wd[2];
  logic [15:0]   ec[2];
  logic [7:0]    pc[2];
  logic cready_m, wready_m, rv_m, ret_en;
  logic [DW-1:0] rd_m;
  int sel;

  int vec, mis;
  int cyc, last_rd, ret_idx, flip_idx, order_err;
  logic [DW-1:0] wq[$], retq[$], wlog[$];
  int waddr[$], raddr[$];
  logic [DW-1:0] mem_lo[int], mem_hi[int];

  rld_app_traffic_gen #(.RL_DQ_WIDTH(72), .APP_AD_WIDTH(AW), .BASE_ADDR(0), .ADDR_STRIDE(4),
    .NUM_CMDS(4), .TIMEOUT(16), .LOOP(0)) dut0 (
    .sysClk(clk), .sysRst_n(rst_n), .start(start[0]), .app_init_done(init_done),
    .app_cmd_valid(cv[0]), .app_cmd_ready(cready_m && sel == 0), .app_cmd_wr(cwr[0]),
    .app_addr(ad[0]), .app_wdata_valid(wv[0]), .app_wdata_ready(wready_m && sel == 0),
    .app_wdata(wd[0]), .app_rdata_valid(rv_m && sel == 0), .app_rdata(rd_m),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .timeout(tmo[0]),
    .err_count(ec[0]), .pass_count(pc[0]));

  rld_app_traffic_gen #(.RL_DQ_WIDTH(72), .APP_AD_WIDTH(AW), .BASE_ADDR(0), .ADDR_STRIDE(4),
    .NUM_CMDS(4), .TIMEOUT(16), .LOOP(1)) dut1 (
    .sysClk(clk), .sysRst_n(rst_n), .start(start[1]), .app_init_done(init_done),
    .app_cmd_valid(cv[1]), .app_cmd_ready(cready_m && sel == 1), .app_cmd_wr(cwr[1]),
    .app_addr(ad[1]), .app_wdata_valid(wv[1]), .app_wdata_ready(wready_m && sel == 1),
    .app_wdata(wd[1]), .app_rdata_valid(rv_m && sel == 1), .app_rdata(rd_m),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .timeout(tmo[1]),
    .err_count(ec[1]), .pass_count(pc[1]));

  // Observe transfers of the selected instance at the active edge.
  task automatic observer();
    logic [DW-1:0] w0, w1;
    int a;
    forever begin
      @(posedge clk);
      cyc++;
      if (wv[sel] && wready_m) begin wq.push_back(wd[sel]); wlog.push_back(wd[sel]); end
      if (cv[sel] && cready_m) begin
        a = int'(ad[sel]);
        if (cwr[sel]) begin
          if (wq.size() < 2) order_err++;
          else begin
            w0 = wq.pop_front(); w1 = wq.pop_front();
            mem_lo[a] = w0; mem_hi[a] = w1;
          end
          waddr.push_back(a);
        end else begin
          retq.push_back(mem_lo.exists(a) ? mem_lo[a] : '0);
          retq.push_back(mem_hi.exists(a) ? mem_hi[a] : '0);
          raddr.push_back(a);
          last_rd = cyc;
        end
      end
    end
  endtask

  // Return read words one per cycle, optionally corrupting one of them.
  task automatic driver();
    logic [DW-1:0] w;
    forever begin
      @(negedge clk);
      if (ret_en && retq.size() > 0) begin
        w = retq.pop_front();
        if (ret_idx == flip_idx) w[5] = ~w[5];
        ret_idx++;
        rv_m = 1'b1; rd_m = w;
      end else begin
        rv_m = 1'b0; rd_m = '0;
      end
    end
  endtask

  task automatic clear_model();
    wq.delete(); retq.delete(); wlog.delete(); waddr.delete(); raddr.delete();
    mem_lo.delete(); mem_hi.delete();
    ret_idx = 0; order_err = 0;
  endtask

  task automatic pulse_start(input int k);
    @(negedge clk); start[k] = 1'b1;
    @(negedge clk); start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int lim, output bit ok);
    ok = 0;
    for (int c = 0; c < lim; c++) begin
      @(negedge clk);
      if (done[k]) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      vec++; if ({cv[k], cwr[k], wv[k], busy[k], done[k], pass[k], tmo[k]} !== 7'b0) begin
        mis++; $display("FAIL reset_flags[%0d]: got %b want 0000000", k,
          {cv[k], cwr[k], wv[k], busy[k], done[k], pass[k], tmo[k]}); end
      vec++; if (ad[k] !== '0) begin mis++; $display("FAIL reset_addr[%0d]: got %h want 0", k, ad[k]); end
      vec++; if (wd[k] !== '0) begin mis++; $display("FAIL reset_wdata[%0d]: got %h want 0", k, wd[k]); end
      vec++; if (ec[k] !== 16'h0) begin mis++; $display("FAIL reset_err[%0d]: got %0d want 0", k, ec[k]); end
      vec++; if (pc[k] !== 8'h0) begin mis++; $display("FAIL reset_pcnt[%0d]: got %0d want 0", k, pc[k]); end
    end
  endtask

  task automatic test_basic();
    bit ok;
    logic [DW-1:0] e3, e4;
    sel = 0; clear_model();
    pulse_start(0);
    wait_done(0, 300, ok);
    vec++; if (!ok) begin mis++; $display("FAIL basic_done: done never rose, want 1"); end
    vec++; if ({pass[0], tmo[0], busy[0]} !== 3'b100) begin mis++;
      $display("FAIL basic_status: pass/tmo/busy got %b want 100", {pass[0], tmo[0], busy[0]}); end
    vec++; if (ec[0] !== 16'd0 || pc[0] !== 8'd0) begin mis++;
      $display("FAIL basic_counts: err %0d pcnt %0d want 0 0", ec[0], pc[0]); end
    vec++; if (wlog.size() != 8 || waddr.size() != 4 || raddr.size() != 4 || order_err != 0) begin mis++;
      $display("FAIL basic_xfers: wdata %0d wcmd %0d rcmd %0d order_err %0d want 8 4 4 0",
        wlog.size(), waddr.size(), raddr.size(), order_err); end
    for (int i = 0; i < 4 && i < waddr.size() && i < raddr.size(); i++) begin
      vec++; if (waddr[i] != 4*i || raddr[i] != 4*i) begin mis++;
        $display("FAIL basic_addr[%0d]: wr %0d rd %0d want %0d", i, waddr[i], raddr[i], 4*i); end
    end
    e3 = {9{16'h0003}}; e4 = {9{16'h0004}};
    if (wlog.size() >= 5) begin
      vec++; if (wlog[3] !== e3 || wlog[4] !== e4) begin mis++;
        $display("FAIL basic_wdata: w3 %h w4 %h want %h %h", wlog[3], wlog[4], e3, e4); end
    end
    repeat (5) @(negedge clk);
    vec++; if (done[0] !== 1'b1 || pass[0] !== 1'b1) begin mis++;
      $display("FAIL basic_hold: done %b pass %b want 1 1", done[0], pass[0]); end
  endtask

  task automatic test_cmd_backpressure();
    bit ok;
    logic [AW-1:0] a0;
    logic w0;
    sel = 0; clear_model(); cready_m = 1'b0;
    pulse_start(0);
    ok = 0;
    for (int c = 0; c < 50; c++) begin @(negedge clk); if (cv[0]) begin ok = 1; break; end end
    vec++; if (!ok) begin mis++; $display("FAIL bp_cmd_valid: no command raised, want 1"); end
    a0 = ad[0]; w0 = cwr[0];
    vec++; if (a0 !== '0 || w0 !== 1'b1) begin mis++;
      $display("FAIL bp_first_cmd: addr %0d wr %b want 0 1", a0, w0); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vec++; if (cv[0] !== 1'b1 || ad[0] !== a0 || cwr[0] !== w0) begin mis++;
        $display("FAIL bp_stable[%0d]: valid %b addr %0d wr %b want 1 %0d %b", c, cv[0], ad[0], cwr[0], a0, w0); end
    end
    cready_m = 1'b1;
    wait_done(0, 300, ok);
    vec++; if (!ok || pass[0] !== 1'b1 || waddr.size() != 4) begin mis++;
      $display("FAIL bp_result: done %b pass %b wcmds %0d want 1 1 4", ok, pass[0], waddr.size()); end
  endtask

  task automatic test_timeout();
    bit ok;
    sel = 0; clear_model(); ret_en = 1'b0;
    pulse_start(0);
    ok = 0;
    for (int c = 0; c < 300; c++) begin @(negedge clk); if (tmo[0]) begin ok = 1; break; end end
    vec++; if (!ok || cyc - last_rd != 16) begin mis++;
      $display("FAIL tmo_latency: seen %b cycles %0d want 1 16", ok, cyc - last_rd); end
    vec++; if ({done[0], pass[0], busy[0]} !== 3'b100 || raddr.size() != 4) begin mis++;
      $display("FAIL tmo_status: done/pass/busy %b reads %0d want 100 4",
        {done[0], pass[0], busy[0]}, raddr.size()); end
    // Late returns after the abort must not be counted as errors.
    ret_en = 1'b1;
    repeat (15) @(negedge clk);
    vec++; if (ec[0] !== 16'd0 || retq.size() != 0) begin mis++;
      $display("FAIL tmo_late_data: err %0d left %0d want 0 0", ec[0], retq.size()); end
  endtask

  task automatic test_read_error();
    bit ok;
    sel = 1; clear_model(); flip_idx = 3;
    pulse_start(1);
    wait_done(1, 300, ok);
    vec++; if (!ok || ec[1] !== 16'd1 || pass[1] !== 1'b0 || tmo[1] !== 1'b0) begin mis++;
      $display("FAIL err_result: done %b err %0d pass %b tmo %b want 1 1 0 0", ok, ec[1], pass[1], tmo[1]); end
    repeat (20) @(negedge clk);
    vec++; if (done[1] !== 1'b1 || busy[1] !== 1'b0 || pc[1] !== 8'd0 || ec[1] !== 16'd1) begin mis++;
      $display("FAIL err_stays_done: done %b busy %b pcnt %0d err %0d want 1 0 0 1",
        done[1], busy[1], pc[1], ec[1]); end
    flip_idx = -1;
  endtask

  task automatic test_loop();
    bit ok;
    logic [DW-1:0] e8, e9, e16;
    sel = 1; clear_model();
    pulse_start(1);
    ok = 0;
    for (int c = 0; c < 2000; c++) begin @(negedge clk); if (pc[1] == 8'd3) begin ok = 1; break; end end
    vec++; if (!ok || ec[1] !== 16'd0) begin mis++;
      $display("FAIL loop_count: pcnt %0d err %0d want 3 0", pc[1], ec[1]); end
    e8 = {9{16'h0100}}; e9 = {9{16'h0101}}; e16 = {9{16'h0200}};
    vec++; if (wlog.size() < 17) begin mis++;
      $display("FAIL loop_wlog: %0d words want >= 17", wlog.size()); end
    else if (wlog[8] !== e8 || wlog[9] !== e9 || wlog[16] !== e16) begin mis++;
      $display("FAIL loop_pattern: %h %h %h want %h %h %h", wlog[8], wlog[9], wlog[16], e8, e9, e16); end
    vec++; if (waddr.size() < 8 || waddr[4] != 0 || waddr[7] != 12) begin mis++;
      $display("FAIL loop_addr: pass-1 addresses do not restart at 0 / end at 12"); end
  endtask

  task automatic test_reset_midrun();
    bit ok;
    logic [DW-1:0] e2;
    sel = 1;
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); if (wv[1] && wd[1][0]) begin ok = 1; break; end
    end
    vec++; if (!ok || busy[1] !== 1'b1) begin mis++;
      $display("FAIL rst_reach_wr_d1: seen %b busy %b want 1 1", ok, busy[1]); end
    rst_n = 1'b0;
    #1;
    vec++; if ({cv[1], wv[1], busy[1], done[1]} !== 4'b0 || ad[1] !== '0 || wd[1] !== '0 ||
               pc[1] !== 8'd0 || ec[1] !== 16'd0) begin mis++;
      $display("FAIL rst_midrun_outputs: valid %b wvalid %b busy %b pcnt %0d addr %0d want 0",
        cv[1], wv[1], busy[1], pc[1], ad[1]); end
    clear_model();
    @(negedge clk); rst_n = 1'b1;
    pulse_start(1);
    ok = 0;
    for (int c = 0; c < 500; c++) begin @(negedge clk); if (pc[1] == 8'd1) begin ok = 1; break; end end
    vec++; if (!ok) begin mis++; $display("FAIL rst_rerun_pass: pcnt %0d want 1", pc[1]); end
    e2 = {9{16'h0002}};
    vec++; if (waddr.size() < 1 || wlog.size() < 3) begin mis++;
      $display("FAIL rst_rerun_xfers: wcmds %0d words %0d want >=1 >=3", waddr.size(), wlog.size()); end
    else if (waddr[0] != 0 || wlog[0] !== '0 || wlog[2] !== e2) begin mis++;
      $display("FAIL rst_rerun_start: addr %0d w0 %h w2 %h want 0 0 %h", waddr[0], wlog[0], wlog[2], e2); end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish, want finish");
    $fatal(1);
  end

  initial begin
    vec = 0; mis = 0; cyc = 0; last_rd = 0; flip_idx = -1; ret_idx = 0; order_err = 0;
    rst_n = 1'b0; init_done = 1'b1; start[0] = 1'b0; start[1] = 1'b0;
    cready_m = 1'b1; wready_m = 1'b1; ret_en = 1'b1; rv_m = 1'b0; rd_m = '0; sel = 0;
    fork
      observer();
      driver();
    join_none
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_cmd_backpressure();
    test_timeout();
    test_read_error();
    test_loop();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
